// File: rtl/demux2_buf_n.sv
// demux2_buf_n
// Two-way demultiplexer with a one-word holding register per output channel.
// A word offered on D/D_VALID is steered by SEL into channel 0 or channel 1.
// Each channel holds at most one word until its consumer takes it.
// Each channel also counts the words it has accepted.
//
// Ports
//   clock       rising-edge clock for all state
//   reset       asynchronous, active-high reset
//   D           input data word (BITS wide)
//   D_VALID     D holds a word to deliver
//   D_READY     block accepts D this cycle (combinational)
//   SEL         destination channel for D (0 or 1)
//   OUT0/OUT1   held word per channel (BITS wide)
//   OUT0_VALID  channel 0 holds an undelivered word
//   OUT1_VALID  channel 1 holds an undelivered word
//   OUT0_READY  channel 0 consumer takes OUT0 this cycle
//   OUT1_READY  channel 1 consumer takes OUT1 this cycle
//   CNT0/CNT1   words accepted per channel, modulo 256
module demux2_buf_n #(
  parameter int BITS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [BITS-1:0] D,
  input  logic            D_VALID,
  output logic            D_READY,
  input  logic            SEL,
  output logic [BITS-1:0] OUT0,
  output logic            OUT0_VALID,
  input  logic            OUT0_READY,
  output logic [BITS-1:0] OUT1,
  output logic            OUT1_VALID,
  input  logic            OUT1_READY,
  output logic [7:0]      CNT0,
  output logic [7:0]      CNT1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_reg [2];
  logic [BITS-1:0] data_reg  [2];
  logic [7:0]      cnt_reg   [2];

  logic [1:0] ready_out;
  logic [1:0] drain;
  logic [1:0] room;
  logic [1:0] accept;

  assign ready_out = {OUT1_READY, OUT0_READY};

  // Steering. An unknown SEL falls into the default branch.
  // That branch keeps D_READY low and accepts nothing.
  always_comb begin
    D_READY = 1'b0;
    accept  = 2'b00;
    case (SEL)
      1'b0: begin
        D_READY   = room[0];
        accept[0] = D_VALID & room[0];
      end
      1'b1: begin
        D_READY   = room[1];
        accept[1] = D_VALID & room[1];
      end
      default: begin
        D_READY = 1'b0;
        accept  = 2'b00;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      // A full channel whose consumer is ready frees its slot this same cycle.
      // That lets a new word enter back-to-back.
      assign drain[gi] = (state_reg[gi] == FULL) & ready_out[gi];
      assign room[gi]  = (state_reg[gi] == EMPTY) | drain[gi];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state_reg[gi] <= EMPTY;
          data_reg[gi]  <= '0;
          cnt_reg[gi]   <= 8'd0;
        end else begin
          case (state_reg[gi])
            EMPTY: begin
              if (accept[gi]) begin
                state_reg[gi] <= FULL;
                data_reg[gi]  <= D;
                cnt_reg[gi]   <= cnt_reg[gi] + 8'd1;
              end
            end
            FULL: begin
              if (accept[gi]) begin
                // Accept only happens here together with a drain.
                // The held word is replaced and the channel stays full.
                data_reg[gi] <= D;
                cnt_reg[gi]  <= cnt_reg[gi] + 8'd1;
              end else if (drain[gi]) begin
                // The data is left in place; only the valid flag drops.
                state_reg[gi] <= EMPTY;
              end
            end
            default: state_reg[gi] <= EMPTY;
          endcase
        end
      end
    end
  endgenerate

  assign OUT0       = data_reg[0];
  assign OUT1       = data_reg[1];
  assign OUT0_VALID = (state_reg[0] == FULL);
  assign OUT1_VALID = (state_reg[1] == FULL);
  assign CNT0       = cnt_reg[0];
  assign CNT1       = cnt_reg[1];

endmodule

// File: tb/tb_demux2_buf_n.sv
// tb_demux2_buf_n
// Directed test of demux2_buf_n with BITS=4.
// Inputs change 1 time unit after a rising edge, and outputs are sampled there too.
module tb_demux2_buf_n;

  localparam int BITS = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [BITS-1:0] d;
  logic            d_valid;
  logic            d_ready;
  logic            sel;
  logic [BITS-1:0] out0;
  logic            out0_valid;
  logic            out0_ready;
  logic [BITS-1:0] out1;
  logic            out1_valid;
  logic            out1_ready;
  logic [7:0]      cnt0;
  logic [7:0]      cnt1;

  int vectors = 0;
  int errors  = 0;

  demux2_buf_n #(.BITS(BITS)) dut (
    .clock      (clock),
    .reset      (reset),
    .D          (d),
    .D_VALID    (d_valid),
    .D_READY    (d_ready),
    .SEL        (sel),
    .OUT0       (out0),
    .OUT0_VALID (out0_valid),
    .OUT0_READY (out0_ready),
    .OUT1       (out1),
    .OUT1_VALID (out1_valid),
    .OUT1_READY (out1_ready),
    .CNT0       (cnt0),
    .CNT1       (cnt1)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out0"},   {28'd0, out0}, 32'd0);
    check({tag, "_out1"},   {28'd0, out1}, 32'd0);
    check({tag, "_v0"},     {31'd0, out0_valid}, 32'd0);
    check({tag, "_v1"},     {31'd0, out1_valid}, 32'd0);
    check({tag, "_cnt0"},   {24'd0, cnt0}, 32'd0);
    check({tag, "_cnt1"},   {24'd0, cnt1}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; d = '0; d_valid = 1'b0; sel = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;

    // Reset acts without a clock edge.
    #2 reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    step();
    reset = 1'b0;
    #1;
    sel = 1'b0; #1 check("rst_rdy_sel0", {31'd0, d_ready}, 32'd1);
    sel = 1'b1; #1 check("rst_rdy_sel1", {31'd0, d_ready}, 32'd1);
    $display("reset: outputs zero, ready on both selects");

    // Single accept to channel 0, with one cycle of latency.
    d = 4'hA; sel = 1'b0; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    check("acc0_out0", {28'd0, out0}, 32'hA);
    check("acc0_v0",   {31'd0, out0_valid}, 32'd1);
    check("acc0_cnt0", {24'd0, cnt0}, 32'd1);
    check("acc0_v1",   {31'd0, out1_valid}, 32'd0);
    check("acc0_cnt1", {24'd0, cnt1}, 32'd0);
    $display("accept 0xA to ch0");

    // Channel 0 is stalled; accept 7 into channel 1.
    sel = 1'b1; d = 4'h7; d_valid = 1'b1;
    #1 check("x1_rdy", {31'd0, d_ready}, 32'd1);
    step();
    d_valid = 1'b0;
    check("x1_out1", {28'd0, out1}, 32'h7);
    check("x1_v1",   {31'd0, out1_valid}, 32'd1);
    check("x1_cnt1", {24'd0, cnt1}, 32'd1);
    check("x1_out0", {28'd0, out0}, 32'hA);
    check("x1_cnt0", {24'd0, cnt0}, 32'd1);
    $display("accept 0x7 to ch1 while ch0 stalled");

    // Drain channel 1; the held value must stay after the drain.
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;
    check("drn1_v1",   {31'd0, out1_valid}, 32'd0);
    check("drn1_out1", {28'd0, out1}, 32'h7);

    // Fill channel 1 with 3, then stall while 5 is pending.
    sel = 1'b1; d = 4'h3; d_valid = 1'b1;
    step();
    check("ld3_out1", {28'd0, out1}, 32'h3);
    check("ld3_cnt1", {24'd0, cnt1}, 32'd2);
    d = 4'h5;
    #1 check("stall_rdy", {31'd0, d_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_out1", {28'd0, out1}, 32'h3);
      check("stall_cnt1", {24'd0, cnt1}, 32'd2);
      check("stall_v1",   {31'd0, out1_valid}, 32'd1);
    end
    out1_ready = 1'b1;
    #1 check("unstall_rdy", {31'd0, d_ready}, 32'd1);
    step();
    d_valid = 1'b0;
    check("repl_out1", {28'd0, out1}, 32'h5);
    check("repl_v1",   {31'd0, out1_valid}, 32'd1);
    check("repl_cnt1", {24'd0, cnt1}, 32'd3);
    step();
    out1_ready = 1'b0;
    check("repl_drn_v1", {31'd0, out1_valid}, 32'd0);
    $display("ch1 stall then drain+replace with 0x5");

    // Fill channel 1 with 9, then offer a word with SEL unknown while both channels are full and stalled.
    sel = 1'b1; d = 4'h9; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    check("ld9_cnt1", {24'd0, cnt1}, 32'd4);
    sel = 1'bx; d = 4'hF; d_valid = 1'b1;
    #1 check("selx_rdy", {31'd0, d_ready}, 32'd0);
    step();
    d_valid = 1'b0; sel = 1'b0;
    check("selx_out0", {28'd0, out0}, 32'hA);
    check("selx_out1", {28'd0, out1}, 32'h9);
    check("selx_cnt0", {24'd0, cnt0}, 32'd1);
    check("selx_cnt1", {24'd0, cnt1}, 32'd4);
    check("selx_v0",   {31'd0, out0_valid}, 32'd1);
    check("selx_v1",   {31'd0, out1_valid}, 32'd1);
    $display("SEL=X with both channels full: nothing accepted");

    // Pulse reset between edges with both channels full.
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    #1 reset = 1'b0;
    sel = 1'b0; #1 check("rel_rdy_sel0", {31'd0, d_ready}, 32'd1);
    sel = 1'b1; #1 check("rel_rdy_sel1", {31'd0, d_ready}, 32'd1);
    $display("mid-cycle reset with both full");

    // Send 256 back-to-back words to channel 0; the counter must wrap to 0.
    step();
    sel = 1'b0; out0_ready = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = i[7:0];
      d = iv[3:0];
      #1 check("bb_rdy", {31'd0, d_ready}, 32'd1);
      step();
      check("bb_out0", {28'd0, out0}, {28'd0, iv[3:0]});
      check("bb_v0",   {31'd0, out0_valid}, 32'd1);
      check("bb_cnt0", {24'd0, cnt0}, {24'd0, iv + 8'd1});
    end
    d_valid = 1'b0;
    check("bb_wrap", {24'd0, cnt0}, 32'd0);
    check("bb_cnt1", {24'd0, cnt1}, 32'd0);
    step();
    out0_ready = 1'b0;
    check("bb_drn_v0", {31'd0, out0_valid}, 32'd0);
    $display("256 back-to-back to ch0, counter wrapped");

    // Fill both channels, then drain both in the same cycle.
    sel = 1'b0; d = 4'h1; d_valid = 1'b1;
    step();
    sel = 1'b1; d = 4'h2;
    step();
    d_valid = 1'b0;
    check("both_v0", {31'd0, out0_valid}, 32'd1);
    check("both_v1", {31'd0, out1_valid}, 32'd1);
    out0_ready = 1'b1; out1_ready = 1'b1;
    step();
    out0_ready = 1'b0; out1_ready = 1'b0;
    check("dual_v0",   {31'd0, out0_valid}, 32'd0);
    check("dual_v1",   {31'd0, out1_valid}, 32'd0);
    check("dual_out0", {28'd0, out0}, 32'h1);
    check("dual_out1", {28'd0, out1}, 32'h2);
    check("dual_cnt0", {24'd0, cnt0}, 32'd1);
    check("dual_cnt1", {24'd0, cnt1}, 32'd1);
    $display("simultaneous drain of both channels");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/demux2_buf_n.md
DEMUX2_BUF_N -- requirements
Module: demux2_buf_n

Interface
REQ-001 Parameter BITS, default 4, data width of input and both output channels.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 D  input  BITS  input data word.
REQ-005 D_VALID  input  1  D holds a word to deliver.
REQ-006 D_READY  output  1  block accepts D this cycle.
REQ-007 SEL  input  1  destination channel for D: 0 selects channel 0, 1 selects channel 1.
REQ-008 OUT0  output  BITS  channel 0 held word.
REQ-009 OUT0_VALID  output  1  OUT0 holds an undelivered word.
REQ-010 OUT0_READY  input  1  channel 0 consumer takes OUT0 this cycle.
REQ-011 OUT1, OUT1_VALID, OUT1_READY  output/output/input  BITS/1/1  same as REQ-008..010 for channel 1.
REQ-012 CNT0  output  8  words accepted into channel 0, modulo 256.
REQ-013 CNT1  output  8  words accepted into channel 1, modulo 256.

Function
REQ-014 Each channel k SHALL have a one-word holding register OUTk and a two-state FSM, EMPTY (OUTk_VALID=0) and FULL (OUTk_VALID=1).
REQ-015 Channel k drain SHALL be a cycle with OUTk_VALID=1 and OUTk_READY=1.
REQ-016 D_READY SHALL be combinational: 1 when the channel selected by SEL is EMPTY or draining this cycle; otherwise 0.
REQ-017 If SEL is neither 0 nor 1 (X/Z), D_READY SHALL be 0 and no word SHALL be accepted.
REQ-018 Accept SHALL occur on a rising edge with D_VALID=1 and D_READY=1; SEL and D SHALL be sampled only at that edge.
REQ-019 On accept to channel k, OUTk SHALL load D and OUTk_VALID SHALL be 1 after that edge (latency one cycle, no combinational D-to-OUTk path).
REQ-020 FSM EMPTY->FULL on accept to k; FULL->EMPTY on drain of k without accept to k; FULL->FULL on simultaneous drain and accept to k, with OUTk replaced by the new D.
REQ-021 While OUTk_VALID=1 and OUTk_READY=0, OUTk SHALL remain stable.
REQ-022 After a drain to EMPTY, OUTk SHALL keep its last value (not cleared).
REQ-023 An accept to one channel SHALL NOT change the other channel's data, valid, or counter.
REQ-024 Both channels SHALL drain independently in the same cycle.
REQ-025 CNTk SHALL increment by 1 on each accept to channel k and wrap 255->0.
REQ-026 With D_VALID=0, D_READY SHALL still reflect REQ-016 and no state SHALL change except drains.

Reset
REQ-027 reset=1 SHALL immediately, without a clock edge, force OUT0=OUT1=0, OUT0_VALID=OUT1_VALID=0, CNT0=CNT1=0, and both FSMs EMPTY.
REQ-028 Reset asserted mid-transfer SHALL discard held words; no accept or drain SHALL occur while reset=1.
REQ-029 After reset, D_READY SHALL be 1 for SEL=0 or SEL=1.

Verification
REQ-030 Reset, then D=4'hA, SEL=0, D_VALID=1 for one edge -> next cycle OUT0=A, OUT0_VALID=1, CNT0=1, OUT1_VALID=0, CNT1=0.
REQ-031 Channel 1 FULL with 4'h3, OUT1_READY=0, SEL=1, D_VALID=1 with D=5 -> D_READY=0, OUT1 stays 3 for 5 cycles; OUT1_READY=1 -> D_READY=1, next cycle OUT1=5, OUT1_VALID=1.
REQ-032 Channel 0 FULL, stalled; SEL=1, D=7 accepted -> OUT1=7, OUT1_VALID=1; OUT0 and CNT0 unchanged.
REQ-033 256 accepts to channel 0 with OUT0_READY=1 throughout -> CNT0 wraps to 0, one word accepted per cycle, OUT0 equals each D one cycle later.
REQ-034 Both channels FULL, reset pulsed between edges -> all outputs 0 at once, D_READY=1 after release.
REQ-035 SEL=X with D_VALID=1 -> D_READY=0; counters and outputs unchanged.
